// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch + data) in front of one synchronous SRAM port.
// Data has priority. A starved fetch is forced through once it has waited STARVE_LIMIT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic              mem_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D,
        OWN_DERR
    } owner_t;

    owner_t           owner_q, owner_d;
    logic             d_wr_q, d_wr_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             fetch_force;
    logic             d_mis;

    // Fetch is word-aligned by contract; its low address bits carry no information.
    logic unused_if_low;
    assign unused_if_low = ^if_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            d_wr_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            d_wr_q   <= d_wr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        owner_d     = OWN_NONE;
        d_wr_d      = 1'b0;
        d_mis       = (d_addr[1:0] != 2'b00);
        fetch_force = if_req && (starve_q == STARVE_MAX);

        if (!rst) begin
            if (d_req && !fetch_force) begin
                d_gnt     = 1'b1;
                mem_addr  = d_addr[ADDR_W-1:2];
                mem_wdata = d_wdata;
                if (d_mis) begin
                    // Misaligned: acknowledged and errored, never reaches memory.
                    owner_d = OWN_DERR;
                end else begin
                    mem_en    = 1'b1;
                    mem_wmask = d_wmask;
                    owner_d   = OWN_D;
                    d_wr_d    = |d_wmask;
                end
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr[ADDR_W-1:2];
                owner_d  = OWN_IF;
            end
        end

        if (if_req && !if_gnt)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        else
            starve_d = '0;
    end

    // Response side: exactly one rvalid for the cycle after each grant.
    always_comb begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D) || (owner_q == OWN_DERR);
        d_err     = (owner_q == OWN_DERR);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = ((owner_q == OWN_D) && !d_wr_q) ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (priority/starvation rules and a shadow word memory).
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [3:0]    d_wmask = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic          mem_init = 1'b1;
    logic [31:0]   sram    [0:255];
    logic [31:0]   ref_mem [0:255];

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read-before-write, data valid one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= 32'h1F2E3D4C ^ (i * 32'h01010101);
        end else if (mem_en) begin
            mem_rdata <= sram[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; d_req = 1'b0; d_wmask = '0; if_addr = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_wmask = 4'hF;
        #2;
        tests++;
        if ({if_gnt, d_gnt, mem_en, mem_wmask} !== 7'b0) begin
            fails++; $display("FAIL reset_grants: got %b want 0", {if_gnt, d_gnt, mem_en, mem_wmask});
        end
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b0) begin
            fails++; $display("FAIL reset_rvalid: got %b want 0", {if_rvalid, d_rvalid, d_err});
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b0) begin
            fails++; $display("FAIL release_rvalid: got %b want 0", {if_rvalid, d_rvalid, d_err});
        end
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        tests++;
        if ({if_gnt, d_gnt, mem_en, mem_wmask, mem_addr} !== {1'b1, 1'b0, 1'b1, 4'h0, 30'h40}) begin
            fails++; $display("FAIL fetch_grant: got %b/%h want 1,0,1,0/40", {if_gnt, d_gnt, mem_en, mem_wmask}, mem_addr);
        end
        tick();
        if_req = 1'b0;
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b100 || if_rdata !== ref_mem[8'h40] || d_rdata !== 32'h0) begin
            fails++; $display("FAIL fetch_resp: got %b %h %h want 100 %h 0", {if_rvalid, d_rvalid, d_err}, if_rdata, d_rdata, ref_mem[8'h40]);
        end
        tick();
    endtask

    task automatic test_write_priority();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h204; d_wmask = 4'hF; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        tests++;
        if ({if_gnt, d_gnt, mem_en, mem_wmask, mem_addr} !== {1'b0, 1'b1, 1'b1, 4'hF, 30'h81}
            || mem_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL write_grant: got %b/%h/%h want 0,1,1,F/81/DEADBEEF", {if_gnt, d_gnt, mem_en, mem_wmask}, mem_addr, mem_wdata);
        end
        ref_mem[8'h81] = 32'hDEADBEEF;
        tick();
        idle_inputs();
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b010 || d_rdata !== 32'h0) begin
            fails++; $display("FAIL write_resp: got %b %h want 010 0", {if_rvalid, d_rvalid, d_err}, d_rdata);
        end
        tick();
        d_req = 1'b1; d_addr = 32'h204; d_wmask = 4'h0;
        tick();
        idle_inputs();
        tests++;
        if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL write_readback: got %b %h want 10 DEADBEEF", {d_rvalid, d_err}, d_rdata);
        end
        tick();
    endtask

    task automatic test_starve();
        if_req = 1'b1; if_addr = 32'h10C;
        d_req = 1'b1; d_addr = 32'h208; d_wmask = 4'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if ({if_gnt, d_gnt} !== ((c == LIM) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL starve_c%0d: got %b want %b", c, {if_gnt, d_gnt}, (c == LIM) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h203; d_wmask = 4'h0;
        @(negedge clk);
        tests++;
        if ({if_gnt, d_gnt, mem_en, mem_wmask} !== {1'b0, 1'b1, 1'b0, 4'h0}) begin
            fails++; $display("FAIL mis_grant: got %b want 0100000", {if_gnt, d_gnt, mem_en, mem_wmask});
        end
        tick();
        idle_inputs();
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b011 || d_rdata !== 32'h0) begin
            fails++; $display("FAIL mis_resp: got %b %h want 011 0", {if_rvalid, d_rvalid, d_err}, d_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        tests++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            fails++; $display("FAIL rstmid_if: got %b want 10", {if_gnt, d_gnt});
        end
        tick();
        d_req = 1'b1; d_addr = 32'h80; d_wmask = 4'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({if_gnt, d_gnt} !== 2'b01) begin
                fails++; $display("FAIL rstmid_d%0d: got %b want 01", c, {if_gnt, d_gnt});
            end
            tick();
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({if_gnt, d_gnt, mem_en, mem_wmask, if_rvalid, d_rvalid, d_err} !== 10'b0
            || {if_rdata, d_rdata} !== 64'h0) begin
            fails++; $display("FAIL rstmid_async: got %b %h %h want 0", {if_gnt, d_gnt, mem_en, mem_wmask, if_rvalid, d_rvalid, d_err}, if_rdata, d_rdata);
        end
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b0) begin
            fails++; $display("FAIL rstmid_release: got %b want 0", {if_rvalid, d_rvalid, d_err});
        end
        // A cleared starve counter lets data win for LIM cycles before fetch is forced.
        for (int c = 0; c <= LIM; c++) begin
            @(negedge clk);
            tests++;
            if ({if_gnt, d_gnt} !== ((c == LIM) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL rstmid_starve_c%0d: got %b want %b", c, {if_gnt, d_gnt}, (c == LIM) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int    stall = 0;
        bit    if_hold = 0, d_hold = 0;
        bit    eg_i, eg_d, mis, een;
        int    kind;
        logic [31:0] pdata, edata;
        logic [7:0]  widx;
        for (int n = 0; n < 400; n++) begin
            if (!if_hold) begin
                if_req  = ($urandom % 4) != 0;
                if_addr = {22'h0, 8'($urandom), 2'($urandom)};
            end
            if (!d_hold) begin
                d_req   = ($urandom % 3) != 0;
                d_addr  = {22'h0, 8'($urandom), (($urandom % 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                d_wmask = ($urandom % 2) ? 4'($urandom) : 4'h0;
                d_wdata = $urandom;
            end
            eg_d = d_req && !(if_req && stall == LIM);
            eg_i = if_req && !eg_d;
            mis  = d_addr[1:0] != 2'b00;
            een  = eg_i || (eg_d && !mis);
            @(negedge clk);
            tests++;
            if ({if_gnt, d_gnt, mem_en} !== {eg_i, eg_d, een}) begin
                fails++; $display("FAIL rnd%0d_grant: got %b want %b", n, {if_gnt, d_gnt, mem_en}, {eg_i, eg_d, een});
            end
            if (een) begin
                tests++;
                if (mem_addr !== (eg_d ? d_addr[AW-1:2] : if_addr[AW-1:2])) begin
                    fails++; $display("FAIL rnd%0d_addr: got %h want %h", n, mem_addr, eg_d ? d_addr[AW-1:2] : if_addr[AW-1:2]);
                end
            end
            if (!(eg_d && mis)) begin
                tests++;
                if (mem_wmask !== (eg_d ? d_wmask : 4'h0)) begin
                    fails++; $display("FAIL rnd%0d_wmask: got %h want %h", n, mem_wmask, eg_d ? d_wmask : 4'h0);
                end
            end
            if (eg_d && !mis && d_wmask != 0) begin
                tests++;
                if (mem_wdata !== d_wdata) begin
                    fails++; $display("FAIL rnd%0d_wdata: got %h want %h", n, mem_wdata, d_wdata);
                end
            end
            kind = 0; pdata = 32'h0;
            if (eg_i) begin
                kind = 1; pdata = ref_mem[if_addr[9:2]];
            end else if (eg_d && mis) begin
                kind = 4;
            end else if (eg_d) begin
                widx = d_addr[9:2];
                if (d_wmask == 0) begin
                    kind = 2; pdata = ref_mem[widx];
                end else begin
                    kind = 3;
                    for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) ref_mem[widx][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end
            stall   = (if_req && !eg_i) ? ((stall == LIM) ? LIM : stall + 1) : 0;
            if_hold = if_req && !eg_i;
            d_hold  = d_req && !eg_d;
            tick();
            tests++;
            if ({if_rvalid, d_rvalid, d_err} !== {kind == 1, kind >= 2, kind == 4}) begin
                fails++; $display("FAIL rnd%0d_rvalid: got %b want %b", n, {if_rvalid, d_rvalid, d_err}, {kind == 1, kind >= 2, kind == 4});
            end
            edata = pdata;
            tests++;
            if ({if_rdata, d_rdata} !== {(kind == 1) ? edata : 32'h0, (kind == 2) ? edata : 32'h0}) begin
                fails++; $display("FAIL rnd%0d_rdata: got %h %h want kind %0d data %h", n, if_rdata, d_rdata, kind, edata);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1F2E3D4C ^ (i * 32'h01010101);
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        test_reset();
        test_fetch();
        test_write_priority();
        test_starve();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
